rr_stream_mux: RTL
==================

Name: rr_stream_mux

Overview:
- Parametrised successor to the team's fixed 4:1 combinational mux.
- Selects among N valid/ready input channels of W-bit data using a round-robin arbiter.
- Drives one registered output channel.
- Sits between multiple producer streams and a single downstream consumer; replaces hand-wired select logic with fair, back-pressure-aware arbitration.

Parameters:
- N, 4, number of input channels (>=1).
- W, 8, data width per channel.
- SEL_W, derived: max(1, clog2(N)), width of the selected-channel index; not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  N  per-channel valid; bit i belongs to channel i
- in_data  in  N*W  channel i occupies bits [i*W +: W]
- in_ready  out  N  per-channel ready
- out_valid  out  1  output register holds a beat
- out_data  out  W  registered data of the accepted beat
- out_sel  out  SEL_W  index of the channel that supplied out_data
- out_ready  in  1  consumer accepts the beat when high with out_valid

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer ptr=0.
  - in_ready=0 while reset is held.
  - Any beat in flight is discarded. No output changes until the first rising clk after rst_n deasserts.
- Load enable: load_en = !out_valid || out_ready (combinational).
- Grant (combinational): scan channels ptr, ptr+1, ... N-1, 0, ... ptr-1. The first with in_valid=1 wins as g. There is no grant if in_valid=0.
- in_ready[i] = load_en && (grant valid) && (i == g). At most one bit of in_ready is high. in_ready must not depend on in_valid of the same channel other than through arbitration.
- Transfer at a clk edge with load_en and grant g:
  - out_data <= channel g data.
  - out_sel <= g.
  - out_valid <= 1.
  - ptr <= (g+1) mod N, wrapping N-1 -> 0.
- load_en with no input valid: out_valid <= 0; out_data and out_sel hold their values.
- !load_en (out_valid=1, out_ready=0): output register, out_sel and ptr hold. All in_ready=0.
- Timing:
  - Latency is 1 cycle from input handshake to out_valid.
  - Sustained throughput is 1 beat/cycle when out_ready stays high.
  - No combinational path from in_valid or in_data to out_*.
- Fairness: with all N channels continuously valid and out_ready=1, grants cycle 0,1,...,N-1,0,... Each channel receives exactly 1 of every N beats.
- N=1: ptr is a constant 0, out_sel=0. The block degenerates to a single register slice.
- Simultaneous events: output drain and input load in the same cycle are allowed; that is the full-throughput case.
- Reset asserted mid-burst takes effect immediately (async), regardless of handshake state.

Optional Feature:
- Macro: RR_STREAM_MUX_PKT_LOCK_EN
- Defined:
  - Adds port in_last (in, N) and port out_last (out, 1, reset 0, registered alongside out_data).
  - When a beat from channel g with in_last[g]=0 is accepted, the arbiter locks to g. Only g may be granted until a beat with in_last[g]=1 is accepted.
  - While locked, no other channel is granted even if g is idle.
  - ptr advances only on acceptance of a last beat.
  - Reset clears the lock.
- Undefined:
  - in_last and out_last do not exist.
  - Every beat is arbitrated independently as described in Behaviour.

Test Plan:
- Reset: hold rst_n=0 with all in_valid=1 -> out_valid=0, out_data=0x00, out_sel=0, in_ready=4'b0000. First beat after release comes from channel 0.
- Round-robin: N=4, in_data = {0x44,0x33,0x22,0x11}, all valid, out_ready=1 for 8 cycles -> out_data sequence 0x11,0x22,0x33,0x44,0x11,0x22,0x33,0x44 and out_sel 0,1,2,3,0,1,2,3, one beat per cycle.
- Skip idle channels: only channels 1 and 3 valid (0xAA, 0xBB) -> out alternates 0xAA (sel 1) and 0xBB (sel 3). Channels 0 and 2 never see in_ready=1.
- Back-pressure: out_ready=0 for 3 cycles with out_valid=1 and data 0x22 -> out_data held at 0x22, in_ready=0000, ptr unchanged. After out_ready=1, the next grant resumes from the channel following 1.
- Async reset mid-stream: drop rst_n between clk edges while out_valid=1 -> out_valid falls to 0 immediately. After release, arbitration restarts at channel 0.
- With RR_STREAM_MUX_PKT_LOCK_EN: channel 2 sends 3 beats with last=0,0,1 while channels 0 and 1 are valid -> all 3 beats are output consecutively with out_sel=2 and out_last=0,0,1. Channel 3 is granted next if valid, otherwise channel 0.

Source files
------------

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-input valid/ready round-robin arbiter feeding one
// registered output slice. Optional packet lock (hold the grant on one
// channel until its last beat) is enabled with RR_STREAM_MUX_PKT_LOCK_EN.
module rr_stream_mux #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in_valid,
  input  logic [N*W-1:0]   in_data,
  output logic [N-1:0]     in_ready,
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
  input  logic [N-1:0]     in_last,
  output logic             out_last,
`endif
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_sel,
  input  logic             out_ready
);

  logic [N-1:0][W-1:0] data_arr;
  logic [SEL_W-1:0]    ptr;
  logic [SEL_W-1:0]    gnt;
  logic [SEL_W-1:0]    gnt_nxt;
  logic [SEL_W:0]      idx_sum;
  logic                gnt_vld;
  logic                load_en;

`ifdef RR_STREAM_MUX_PKT_LOCK_EN
  logic                locked;
  logic [SEL_W-1:0]    lock_ch;
`endif

  assign data_arr = in_data;
  assign load_en  = !out_valid || out_ready;
  // pointer after a grant, wrapping N-1 -> 0 (constant 0 when N=1)
  assign gnt_nxt  = (gnt == SEL_W'(N-1)) ? '0 : gnt + SEL_W'(1);

  // round-robin scan from ptr; descending loop so the closest channel wins
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    idx_sum = '0;
    for (int k = N-1; k >= 0; k--) begin
      idx_sum = {1'b0, ptr} + (SEL_W+1)'(k);
      if (idx_sum >= (SEL_W+1)'(N)) idx_sum = idx_sum - (SEL_W+1)'(N);
      if (in_valid[idx_sum[SEL_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt     = idx_sum[SEL_W-1:0];
      end
    end
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
    // a locked packet owns the arbiter even while its channel is idle
    if (locked) begin
      gnt     = lock_ch;
      gnt_vld = in_valid[lock_ch];
    end
`endif
  end

  // one-hot ready to the granted channel; held low during reset
  for (genvar i = 0; i < N; i++) begin : g_rdy
    assign in_ready[i] = rst_n && load_en && gnt_vld && (gnt == SEL_W'(i));
  end

  // output slice, pointer and lock state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
      out_last  <= 1'b0;
      locked    <= 1'b0;
      lock_ch   <= '0;
`endif
    end else if (load_en) begin
      if (gnt_vld) begin
        out_valid <= 1'b1;
        out_data  <= data_arr[gnt];
        out_sel   <= gnt;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
        out_last  <= in_last[gnt];
        if (in_last[gnt]) begin
          locked <= 1'b0;
          ptr    <= gnt_nxt;
        end else begin
          locked  <= 1'b1;
          lock_ch <= gnt;
        end
`else
        ptr       <= gnt_nxt;
`endif
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
